// File: rtl/sram_mc_arbiter.sv
// Multi-channel controller for a 16-bit asynchronous SRAM: round-robin grant,
// timed word accesses, byte-lane writes and incrementing read bursts.
module sram_mc_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int AW        = 20,
  parameter int WAIT_CYC  = 7,
  parameter int BURST_LEN = 16
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic [NUM_CH-1:0]                            i_req,
  input  logic [NUM_CH-1:0]                            i_wr,
  input  logic [NUM_CH-1:0]                            i_burst,
  input  logic [NUM_CH*AW-1:0]                         i_addr,
  input  logic [NUM_CH*16-1:0]                         i_wdata,
  input  logic [NUM_CH*2-1:0]                          i_be,
  output logic [NUM_CH-1:0]                            o_gnt,
  output logic [NUM_CH-1:0]                            o_rvalid,
  output logic [15:0]                                  o_rdata,
  output logic [NUM_CH-1:0]                            o_done,
  output logic                                         o_busy,
  output logic [AW-1:0]                                o_SRAM_ADDR,
  output logic                                         o_SRAM_WE_N,
  output logic                                         o_SRAM_CE_N,
  output logic                                         o_SRAM_OE_N,
  output logic                                         o_SRAM_LB_N,
  output logic                                         o_SRAM_UB_N,
  inout  wire  [15:0]                                  io_SRAM_DQ,
  output logic                                         o_dbg_state,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_dbg_rr
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW = $clog2(WAIT_CYC + 1);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [WW-1:0] WC_LAST = WW'(WAIT_CYC);
  localparam logic [BW-1:0] BC_LAST = BW'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        state;
  logic [WW-1:0] wc;
  logic [BW-1:0] bc;
  logic [PW-1:0] rr, ch_q, gnt_idx;
  logic          gnt_any;
  logic          wr_q, burst_q;
  logic [15:0]   wdata_q;
  logic [1:0]    be_q;
  logic [AW-1:0] addr_q;
  logic          access, we_win;

  // Scan downward so the lowest offset from the rr pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_req[(int'(rr) + i) % NUM_CH]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'((int'(rr) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (state == IDLE && gnt_any && i_rst) o_gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      wc       <= '0;
      bc       <= '0;
      rr       <= '0;
      ch_q     <= '0;
      wr_q     <= 1'b0;
      burst_q  <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      addr_q   <= '0;
      o_rdata  <= '0;
      o_rvalid <= '0;
      o_done   <= '0;
    end else begin
      o_rvalid <= '0;
      o_done   <= '0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state   <= ACCESS;
            ch_q    <= gnt_idx;
            wr_q    <= i_wr[gnt_idx];
            burst_q <= i_burst[gnt_idx] & ~i_wr[gnt_idx];
            addr_q  <= i_addr[gnt_idx*AW +: AW];
            wdata_q <= i_wdata[gnt_idx*16 +: 16];
            be_q    <= i_be[gnt_idx*2 +: 2];
            wc      <= '0;
            bc      <= '0;
            rr      <= (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        ACCESS: begin
          if (wc != WC_LAST) begin
            wc <= wc + 1'b1;
          end else begin
            if (!wr_q) begin
              o_rdata        <= io_SRAM_DQ;
              o_rvalid[ch_q] <= 1'b1;
            end
            if (burst_q && bc != BC_LAST) begin
              addr_q <= addr_q + 1'b1;
              bc     <= bc + 1'b1;
              wc     <= '0;
            end else begin
              state        <= IDLE;
              o_done[ch_q] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // WE_N is held off the first (address setup) and last (data hold) word cycles,
  // except at the minimum WAIT_CYC where only the second cycle remains.
  assign access = (state == ACCESS);
  assign we_win = (WAIT_CYC == 1) ? (wc == WC_LAST) : ((wc != '0) && (wc != WC_LAST));

  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_CE_N = ~access;
  assign o_SRAM_OE_N = ~(access & ~wr_q);
  assign o_SRAM_WE_N = ~(access & wr_q & we_win);
  assign o_SRAM_LB_N = ~(access & (wr_q ? be_q[0] : 1'b1));
  assign o_SRAM_UB_N = ~(access & (wr_q ? be_q[1] : 1'b1));
  assign io_SRAM_DQ  = (access & wr_q) ? wdata_q : 16'bz;
  assign o_busy      = access;
  assign o_dbg_state = state;
  assign o_dbg_rr    = rr;
endmodule
